// File: rtl/sd_sector_packer_if.sv
// Host byte stream in, SD write-controller word stream out, plus status
// for the 512-byte sector packer.
interface sd_sector_packer_if #(
  parameter int unsigned AW = 9
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [AW:0]   byte_count;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done, byte_count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done, byte_count
  );
endinterface

// File: rtl/sd_sector_packer.sv
// Collects host bytes into a sector store, then drains it to the SD write
// controller as big-endian 16-bit words, zero-padding any unwritten tail.
module sd_sector_packer #(
  parameter int unsigned SECTOR_BYTES = 512,
  parameter int unsigned AW           = 9
) (
  input logic               clk,
  input logic               rst_n,
  sd_sector_packer_if.slave bus
);
  localparam int unsigned     Words    = SECTOR_BYTES / 2;
  localparam logic [AW:0]     LastByte = (AW+1)'(SECTOR_BYTES - 1);
  localparam logic [AW-2:0]   LastWord = (AW-1)'(Words - 1);

  typedef enum logic [1:0] {StFill, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   byte_count_q, byte_count_d;
  logic [AW-2:0] rptr_q, rptr_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;
  logic          accept;
  logic          load;
  logic [7:0]    rd_hi, rd_lo;

  // Even and odd bytes live in separate banks so a whole word reads at once.
  logic [7:0] mem_hi [Words];
  logic [7:0] mem_lo [Words];

  assign accept = bus.in_valid && (state_q == StFill);

  always_ff @(posedge clk) begin
    if (accept) begin
      if (byte_count_q[0]) mem_lo[byte_count_q[AW-1:1]] <= bus.in_data;
      else                 mem_hi[byte_count_q[AW-1:1]] <= bus.in_data;
    end
  end

  // Bytes past the fill level read as zero; the store itself is never cleared.
  always_comb begin
    rd_hi = ({1'b0, rptr_q, 1'b0} < byte_count_q) ? mem_hi[rptr_q] : 8'h00;
    rd_lo = ({1'b0, rptr_q, 1'b1} < byte_count_q) ? mem_lo[rptr_q] : 8'h00;
  end

  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    rptr_d       = rptr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    done_d       = 1'b0;
    load         = 1'b0;

    case (state_q)
      StFill: begin
        if (accept) byte_count_d = byte_count_q + 1'b1;
        if ((accept && byte_count_q == LastByte) ||
            (bus.flush && (accept || byte_count_q != '0))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!out_valid_q) begin
          load = 1'b1;
        end else if (bus.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            done_d      = 1'b1;
            state_d     = StDone;
          end else begin
            load = 1'b1;
          end
        end
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = {rd_hi, rd_lo};
          out_last_d  = (rptr_q == LastWord);
          rptr_d      = rptr_q + 1'b1;
        end
      end
      StDone: begin
        byte_count_d = '0;
        rptr_d       = '0;
        state_d      = StFill;
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFill;
      byte_count_q <= '0;
      rptr_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      rptr_q       <= rptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
    end
  end

  assign bus.in_ready   = (state_q == StFill);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = (state_q != StFill);
  assign bus.done       = done_q;
  assign bus.byte_count = byte_count_q;
endmodule

// File: tb/tb_sd_sector_packer.sv
// Scoreboard bench for sd_sector_packer: expected words are queued when a
// sector is closed and popped against the words the DUT hands over.
module tb_sd_sector_packer;
  localparam int unsigned AW = 9;
  localparam int unsigned SB = 512;
  localparam int unsigned NW = SB / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sd_sector_packer_if #(.AW(AW)) bus();
  sd_sector_packer #(.SECTOR_BYTES(SB), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          last_at[$];
  logic [7:0]  model[SB];
  int          nbytes = 0;
  int          done_cnt, stall_bad, bc_bad;
  bit          timed_out;

  task automatic push_sector();
    logic [7:0] hi, lo;
    for (int k = 0; k < NW; k++) begin
      hi = (2*k < nbytes) ? model[2*k] : 8'h00;
      lo = (2*k+1 < nbytes) ? model[2*k+1] : 8'h00;
      exp_q.push_back({hi, lo});
    end
    nbytes = 0;
  endtask

  task automatic feed(input logic [7:0] b, input bit fl);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.flush    = fl;
    if (nbytes < SB) model[nbytes] = b;
    nbytes++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    if (fl || nbytes == SB) push_sector();
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    if (nbytes > 0) push_sector();
  endtask

  // Records handshaked words, out_last positions, done pulses, stall stability.
  task automatic collect(input bit bp, input int exp_bc);
    int cyc = 0;
    int ph = 0;
    int after = -1;
    bit stalled = 1'b0;
    logic [15:0] held = '0;
    got_q.delete(); last_at.delete();
    done_cnt = 0; stall_bad = 0; bc_bad = 0; timed_out = 1'b0;
    while (after != 0) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin timed_out = 1'b1; break; end
      if (bus.done) done_cnt++;
      if (after > 0) after--;
      bus.out_ready = bp ? (ph % 4 == 0 || ph % 4 == 3) : 1'b1;
      ph++;
      if (bus.out_valid) begin
        if (bus.byte_count != (AW+1)'(exp_bc)) bc_bad++;
        if (stalled && bus.out_data !== held) stall_bad++;
        stalled = !bus.out_ready;
        held    = bus.out_data;
        if (bus.out_ready) begin
          got_q.push_back(bus.out_data);
          if (bus.out_last) begin
            last_at.push_back(got_q.size() - 1);
            bus.in_valid = 1'b0;
            after = 3;
          end
        end
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=0000", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%b exp=0", bus.out_last); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.byte_count !== '0) begin errors++; $display("FAIL rst_byte_count got=%0d exp=0", bus.byte_count); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_full_sector();
    for (int i = 0; i < SB; i++) feed(8'(i), 1'b0);
    checks++; if (bus.byte_count !== 10'd512) begin errors++; $display("FAIL full_count got=%0d exp=512", bus.byte_count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
    collect(1'b0, 512);
    checks++; if (timed_out || got_q.size() != NW) begin errors++; $display("FAIL full_words got=%0d exp=%0d", got_q.size(), NW); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL full_word got=%h exp=%h", g, e); end
    end
    exp_q.delete();
    checks++; if (last_at.size() != 1 || last_at[0] != NW - 1) begin errors++; $display("FAIL full_last got=%0d marks exp=1 at 255", last_at.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done got=%0d exp=1", done_cnt); end
    checks++; if (bus.byte_count !== '0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_after got=%0d/%b exp=0/1", bus.byte_count, bus.in_ready); end
  endtask

  task automatic test_partial_flush();
    feed(8'hAA, 1'b0); feed(8'hBB, 1'b0); feed(8'hCC, 1'b0);
    do_flush();
    collect(1'b0, 3);
    checks++; if (timed_out || got_q.size() != NW) begin errors++; $display("FAIL part_words got=%0d exp=%0d", got_q.size(), NW); end
    checks++; if (got_q.size() > 1 && (got_q[0] !== 16'hAABB || got_q[1] !== 16'hCC00)) begin errors++; $display("FAIL part_head got=%h %h exp=aabb cc00", got_q[0], got_q[1]); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL part_word got=%h exp=%h", g, e); end
    end
    exp_q.delete();
    checks++; if (last_at.size() != 1 || last_at[0] != NW - 1) begin errors++; $display("FAIL part_last got=%0d marks exp=1 at 255", last_at.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL part_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_flush_same_cycle();
    feed(8'h11, 1'b0); feed(8'h22, 1'b1);
    collect(1'b0, 2);
    checks++; if (timed_out || got_q.size() != NW) begin errors++; $display("FAIL same_words got=%0d exp=%0d", got_q.size(), NW); end
    checks++; if (got_q.size() > 0 && got_q[0] !== 16'h1122) begin errors++; $display("FAIL same_word0 got=%h exp=1122", got_q[0]); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL same_word got=%h exp=%h", g, e); end
    end
    exp_q.delete();
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL same_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_empty_flush();
    int bad = 0;
    do_flush();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.done || bus.busy || !bus.in_ready) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL empty_flush got=%0d active cycles exp=0", bad); end
    checks++; if (bus.byte_count !== '0) begin errors++; $display("FAIL empty_count got=%0d exp=0", bus.byte_count); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < SB; i++) feed(8'(i * 7 + 3), 1'b0);
    bus.in_data  = 8'hEE;
    bus.in_valid = 1'b1;
    collect(1'b1, 512);
    checks++; if (timed_out || got_q.size() != NW) begin errors++; $display("FAIL bp_words got=%0d exp=%0d", got_q.size(), NW); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL bp_word got=%h exp=%h", g, e); end
    end
    exp_q.delete();
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable got=%0d changes exp=0", stall_bad); end
    checks++; if (bc_bad != 0) begin errors++; $display("FAIL bp_frozen got=%0d bad counts exp=0", bc_bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done got=%0d exp=1", done_cnt); end
    checks++; if (bus.byte_count !== '0) begin errors++; $display("FAIL bp_after got=%0d exp=0", bus.byte_count); end
  endtask

  task automatic test_reset_mid_drain();
    int hs = 0;
    int dn = 0;
    for (int i = 0; i < SB; i++) feed(8'(255 - i), 1'b0);
    exp_q.delete();
    for (int c = 0; c < 100 && hs < 11; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (bus.out_valid) hs++;
    end
    checks++; if (hs != 11) begin errors++; $display("FAIL mid_reach got=%0d exp=11", hs); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.byte_count !== '0) begin errors++; $display("FAIL mid_count got=%0d exp=0", bus.byte_count); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL mid_done got=%0d exp=0", dn); end
    feed(8'h5A, 1'b0); feed(8'hA5, 1'b1);
    collect(1'b0, 2);
    checks++; if (timed_out || got_q.size() != NW) begin errors++; $display("FAIL mid_words got=%0d exp=%0d", got_q.size(), NW); end
    checks++; if (got_q.size() > 0 && got_q[0] !== 16'h5AA5) begin errors++; $display("FAIL mid_word0 got=%h exp=5aa5", got_q[0]); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL mid_word got=%h exp=%h", g, e); end
    end
    exp_q.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_full_sector();
    test_partial_flush();
    test_flush_same_cycle();
    test_empty_flush();
    test_backpressure();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sd_sector_packer.md
Name: sd_sector_packer

Overview:
Write-direction counterpart of the 512-byte SD sector read buffer. It accepts a host byte stream into an internal 512-byte sector store. Once the sector is full, or on flush, it drains the sector to the SD write controller as 256 big-endian 16-bit words. Sits between the host/CPU write path and the SD card write command engine.

Parameters:
SECTOR_BYTES, 512, bytes per sector; must be even; words per sector = SECTOR_BYTES/2
AW, 9, byte address width, log2(SECTOR_BYTES)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  host byte valid
in_data  in  8  host byte
in_ready  out  1  packer can accept a byte this cycle
flush  in  1  close a partial sector, zero-pad the remainder and drain
out_valid  out  1  out_data holds a valid word
out_data  out  16  sector word, {byte[2k], byte[2k+1]}
out_ready  in  1  SD write controller accepts the word
out_last  out  1  asserted with word 255 (final word of the sector)
busy  out  1  high in DRAIN and DONE
done  out  1  one-cycle pulse after the final word handshake
byte_count  out  AW+1  bytes accepted into the current sector, 0..512

Behaviour:
- Reset (async, rst_n=0): state=FILL; wptr, rptr and byte_count = 0; out_valid=0, out_data=0, out_last=0, done=0, busy=0. in_ready=1 once in FILL. Storage contents are don't-care; padding is generated by logic, not by clearing the array.
- States: FILL -> DRAIN -> DONE -> FILL.
- Input handshake: in_ready = (state==FILL). A byte is accepted when in_valid & in_ready; it is written to mem[byte_count] and byte_count increments.
- FILL -> DRAIN triggers:
  - The 512th byte is accepted (byte_count becomes 512).
  - flush=1 with byte_count>0. If a byte is accepted in the same cycle, that byte is stored first and counted.
  - flush with byte_count==0 and no byte accepted is ignored: the block stays in FILL and emits no words.
- Padding: during drain, any byte index >= byte_count reads as 8'h00.
- DRAIN output timing:
  - On the cycle after entering DRAIN, out_valid=1 and out_data = word 0.
  - out_data and out_last hold stable while out_valid & !out_ready.
  - On each out_valid & out_ready, the next word is registered for the following cycle with out_valid still high. Throughput is one word per cycle with no bubbles.
  - out_last=1 exactly while word 255 is presented.
- Handshake on word 255 (out_last): next cycle out_valid=0, out_last=0, state=DONE, done=1.
- DONE lasts one cycle: wptr, rptr and byte_count clear to 0, then state returns to FILL.
- in_ready is 0 throughout DRAIN and DONE. in_valid asserted in those states is not accepted and causes no write.
- flush asserted during DRAIN or DONE is ignored.
- Word k (0..255) = {byte(2k), byte(2k+1)}, with each byte from mem or 8'h00 per the padding rule.
- out_ready asserted while out_valid=0 has no effect.
- Reset asserted mid-DRAIN aborts the sector immediately: outputs return to reset values, no done pulse, and the partial sector is discarded.

Test Plan:
- Full sector: feed bytes i[7:0] for i=0..511 with in_valid=1 continuously, out_ready=1 -> byte_count reaches 512, in_ready drops; 256 consecutive words 16'h0001, 16'h0203 ... 16'hFEFF (second half repeats the same pattern); out_last only on word 255; done pulses once; then byte_count=0 and in_ready=1.
- Partial flush: bytes AA, BB, CC then flush -> word0=16'hAABB, word1=16'hCC00, words 2..255=16'h0000, out_last on word 255.
- Flush on the accepting cycle: bytes 11, 22 with flush in the same cycle as 22 -> word0=16'h1122, remaining 255 words=16'h0000.
- Empty flush: flush with byte_count=0 -> out_valid stays 0, no done, in_ready stays 1.
- Backpressure: full sector with out_ready toggling 1,0,0,1 ... -> out_data stable while stalled; 256 handshakes in order with no drop or duplicate; in_valid held high during drain accepts nothing (byte_count frozen at 512).
- Reset mid-drain: pull rst_n low after word 10 -> out_valid=0 and byte_count=0 asynchronously, no done pulse; a following 2-byte write plus flush yields word0 equal to the new data.
